multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 148 ++++++++++++++
 tb/tb_multicycle_controller.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM for a multicycle MIPS-style datapath.
// Drives datapath enables, mux selects and the ALU operation code from the
// registered state. Opcode only affects the next state, never the outputs.
// Optional feature: define BNE_EN to add the bne instruction (BNEEX state).
// Handshake: none; the controller advances one state per clock, and the
// current state is exposed on `state` for observation.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12
  } state_t;

  state_t     cur_state;
  state_t     nxt_state;
  state_t     out_state;
  logic       pcwrite;
  logic       branch;
  logic       branchne;
  logic [1:0] aluop;
  logic       legal;

  // State register; reset wins over any pending transition.
  always_ff @(posedge clk) begin
    if (reset) cur_state <= FETCH;
    else       cur_state <= nxt_state;
  end

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    nxt_state = FETCH;
    case (cur_state)
      FETCH:   nxt_state = DECODE;
      DECODE: begin
        case (op)
          6'b100011, 6'b101011: nxt_state = MEMADR;
          6'b000000:            nxt_state = RTYPEEX;
          6'b000100:            nxt_state = BEQEX;
          6'b001000:            nxt_state = ADDIEX;
          6'b000010:            nxt_state = JEX;
`ifdef BNE_EN
          6'b000101:            nxt_state = BNEEX;
`endif
          default:              nxt_state = FETCH;
        endcase
      end
      MEMADR:  nxt_state = (op == 6'b100011) ? MEMRD : MEMWR;
      MEMRD:   nxt_state = MEMWB;
      RTYPEEX: nxt_state = RTYPEWB;
      ADDIEX:  nxt_state = ADDIWB;
      default: nxt_state = FETCH;
    endcase
  end

  // While reset is held the outputs present FETCH values, so an abandoned
  // instruction cannot issue a late memory or register write.
  assign out_state = reset ? FETCH : cur_state;

  // Moore output decode from the (reset-overridden) state.
  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    branchne = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    legal    = 1'b1;
    case (out_state)
      FETCH:   begin alusrcb = 2'b01; irwrite = 1'b1; pcwrite = 1'b1; end
      DECODE:  alusrcb = 2'b11;
      MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      MEMRD:   iord = 1'b1;
      MEMWB:   begin memtoreg = 1'b1; regwrite = 1'b1; end
      MEMWR:   begin iord = 1'b1; memwrite = 1'b1; end
      RTYPEEX: begin alusrca = 1'b1; aluop = 2'b10; end
      RTYPEWB: begin regdst = 1'b1; regwrite = 1'b1; end
      BEQEX:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; end
      ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      ADDIWB:  regwrite = 1'b1;
      JEX:     begin pcsrc = 2'b10; pcwrite = 1'b1; end
`ifdef BNE_EN
      BNEEX:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branchne = 1'b1; end
`endif
      default: legal = 1'b0;
    endcase
  end

  // ALU decoder: fixed add/sub for aluop 00/01, funct field for R-type.
  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
    if (!legal) alucontrol = 3'b000;
  end

  assign pcen  = pcwrite | (branch & zero) | (branchne & ~zero);
  assign state = cur_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed instruction sequences for the
// multicycle controller. The driver pushes the hand-computed output vector
// for each cycle into exp_q; a monitor on the falling edge pops and compares.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite;
  logic       alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  localparam int W = 19;
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .state      (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: state, pcen, memwrite, irwrite, regwrite, alusrca, iord,
  // memtoreg, regdst, alusrcb, pcsrc, alucontrol.
  function automatic logic [W-1:0] ev(input logic [3:0] st, input logic pc,
      input logic mw, input logic irw, input logic rw, input logic asa,
      input logic io, input logic mtr, input logic rd, input logic [1:0] asb,
      input logic [1:0] pcs, input logic [2:0] ac);
    return {st, pc, mw, irw, rw, asa, io, mtr, rd, asb, pcs, ac};
  endfunction

  wire [W-1:0] obs = {state, pcen, memwrite, irwrite, regwrite, alusrca, iord,
                      memtoreg, regdst, alusrcb, pcsrc, alucontrol};

  // Hand-derived per-state expectations.
  logic [W-1:0] v_f, v_d, v_ma, v_mr, v_mwb, v_mw, v_rwb, v_ax, v_awb, v_j;

  function automatic logic [W-1:0] v_rx(input logic [2:0] ac);
    return ev(4'd6, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, ac);
  endfunction

  function automatic logic [W-1:0] v_beq(input logic z);
    return ev(4'd8, z, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 3'b110);
  endfunction

  function automatic logic [W-1:0] v_bne(input logic z);
    return ev(4'd12, ~z, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 3'b110);
  endfunction

  // scoreboard monitor: compare one expected vector per cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL cycle_vec t=%0t got=%b exp=%b (state got %0d exp %0d)",
                 $time, obs, e, obs[W-1 -: 4], e[W-1 -: 4]);
      end
    end
  end

  // driver: expect vector for the current cycle, then advance one clock
  task automatic cyc(input logic [W-1:0] e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fn_tab [6];
  logic [2:0] ac_tab [6];

  initial begin
    v_f   = ev(4'd0,  1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
    v_d   = ev(4'd1,  0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010);
    v_ma  = ev(4'd2,  0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 3'b010);
    v_mr  = ev(4'd3,  0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010);
    v_mwb = ev(4'd4,  0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010);
    v_mw  = ev(4'd5,  0, 1, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010);
    v_rwb = ev(4'd7,  0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010);
    v_ax  = ev(4'd9,  0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 3'b010);
    v_awb = ev(4'd10, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010);
    v_j   = ev(4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010);
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    ac_tab = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};

    reset = 1'b1; op = 6'b111111; funct = 6'b000000; zero = 1'b0;
    @(posedge clk); #1;
    cyc(v_f);                      // second reset cycle: FETCH outputs
    reset = 1'b0;

    // lw: 0,1,2,3,4
    op = 6'b100011;
    cyc(v_f); cyc(v_d); cyc(v_ma); cyc(v_mr); cyc(v_mwb);
    // sw: 0,1,2,5
    op = 6'b101011;
    cyc(v_f); cyc(v_d); cyc(v_ma); cyc(v_mw);
    // R-type over the funct table
    op = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      funct = fn_tab[i];
      cyc(v_f); cyc(v_d); cyc(v_rx(ac_tab[i])); cyc(v_rwb);
    end
    funct = 6'b000000;
    // beq taken and not taken
    op = 6'b000100;
    zero = 1'b1; cyc(v_f); cyc(v_d); cyc(v_beq(1'b1));
    zero = 1'b0; cyc(v_f); cyc(v_d); cyc(v_beq(1'b0));
    // addi
    op = 6'b001000;
    cyc(v_f); cyc(v_d); cyc(v_ax); cyc(v_awb);
    // j
    op = 6'b000010;
    cyc(v_f); cyc(v_d); cyc(v_j);
    // unknown opcode
    op = 6'b111111;
    cyc(v_f); cyc(v_d);
    // bne, zero=0 then zero=1
    op = 6'b000101;
`ifdef BNE_EN
    zero = 1'b0; cyc(v_f); cyc(v_d); cyc(v_bne(1'b0));
    zero = 1'b1; cyc(v_f); cyc(v_d); cyc(v_bne(1'b1));
`else
    zero = 1'b0; cyc(v_f); cyc(v_d);
    zero = 1'b1; cyc(v_f); cyc(v_d);
`endif
    zero = 1'b0;
    // sw aborted by reset during MEMADR: outputs go to FETCH values at once
    op = 6'b101011;
    cyc(v_f); cyc(v_d);
    reset = 1'b1;
    cyc(ev(4'd2, 1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010));
    reset = 1'b0;
    // restarts from FETCH; run a clean j to finish
    op = 6'b000010;
    cyc(v_f); cyc(v_d); cyc(v_j);
    cyc(v_f);

    // let the monitor drain, bounded
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
